tt_blk_sel: RTL and testbench

Per-tile selection receiver in the mux branch.
- Counts design-select pulses broadcast by the controller and compares the count against a hardwired block ID built from tie-lo/tie-hi primitive cells.
- On a matching commit, sequences the user-design enable and reset outputs.
- Sits directly downstream of the tie cells: consumes their constant outputs as its ID and drives the tile's enable/reset gating.

---
 rtl/tt_blk_sel.sv | 157 +++++++++++++++
 tb/tb_tt_blk_sel.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tt_blk_sel.sv
// tt_blk_sel: per-tile selection receiver. It counts design-select pulses and
// compares the count with the tie-cell block ID. On a match it sequences the user enable and reset.
// Latency: 1 cycle from a controller input to any output. All outputs are registered.
// Backpressure: none. The controller strobes are level/edge inputs and are never stalled.
//
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   blk_id      : hardwired block ID (static, compared combinationally)
//   sel_rst     : clear the select counter and re-arm counting (highest priority)
//   sel_inc     : increment strobe, counted on its rising edge
//   sel_ena     : commit (rising edge) and hold (level) of the selection
//   blk_ena     : user design enable
//   blk_rst_n   : user design reset, active-low
//   busy        : high while counting or while reset is being held in the guard phase
//   ovf         : sticky flag, set when an increment arrives with the counter at all-ones
//
// Build option: define TT_BLK_SEL_GUARD_EN to add the guard phase. In that phase the design
// is enabled while reset is held for 2^GUARD_W cycles. Without it, reset is released one
// cycle after the enable.
module tt_blk_sel #(
  parameter int ADDR_W  = 10,
  parameter int GUARD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] blk_id,
  input  logic              sel_rst,
  input  logic              sel_inc,
  input  logic              sel_ena,
  output logic              blk_ena,
  output logic              blk_rst_n,
  output logic              busy,
  output logic              ovf
);

  // GUARD_W sizes the guard counter. It must be valid in every build.
  if (GUARD_W < 1) begin : g_guard_w_range
    $error("tt_blk_sel: GUARD_W must be at least 1");
  end

`ifdef TT_BLK_SEL_GUARD_EN
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GUARD, S_ACTIVE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ACTIVE} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                inc_dly_q, ena_dly_q;
  logic                blk_ena_q, blk_ena_d;
  logic                blk_rst_n_q, blk_rst_n_d;
  logic                busy_q, busy_d;
`ifdef TT_BLK_SEL_GUARD_EN
  logic [GUARD_W-1:0]  guard_q, guard_d;
`endif

  logic inc_edge, ena_rise, id_match;

  assign inc_edge = sel_inc & ~inc_dly_q;
  assign ena_rise = sel_ena & ~ena_dly_q;
  // A saturated count is not trusted, even if it happens to equal the ID.
  assign id_match = (cnt_q == blk_id) && !ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef TT_BLK_SEL_GUARD_EN
    guard_d = guard_q;
`endif
    if (sel_rst) begin
      state_d = S_COUNT;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef TT_BLK_SEL_GUARD_EN
      guard_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: ;
        S_COUNT: begin
          // A commit takes precedence. The compare uses the count before any
          // increment that coincides with the commit, and that increment is dropped.
          if (ena_rise) begin
`ifdef TT_BLK_SEL_GUARD_EN
            state_d = id_match ? S_GUARD : S_IDLE;
            guard_d = '0;
`else
            state_d = id_match ? S_ACTIVE : S_IDLE;
`endif
          end else if (inc_edge) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + ADDR_W'(1);
          end
        end
`ifdef TT_BLK_SEL_GUARD_EN
        S_GUARD: begin
          guard_d = guard_q + GUARD_W'(1);
          if (!sel_ena)      state_d = S_IDLE;
          else if (&guard_q) state_d = S_ACTIVE;
        end
`endif
        S_ACTIVE: begin
          if (!sel_ena) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state, so the registers reflect the state they enter.
`ifdef TT_BLK_SEL_GUARD_EN
    blk_ena_d   = (state_d == S_GUARD) || (state_d == S_ACTIVE);
    blk_rst_n_d = (state_d == S_ACTIVE);
    busy_d      = (state_d == S_COUNT) || (state_d == S_GUARD);
`else
    // Reset is held through the first enabled cycle and released from the second one on.
    blk_ena_d   = (state_d == S_ACTIVE);
    blk_rst_n_d = (state_d == S_ACTIVE) && (state_q == S_ACTIVE);
    busy_d      = (state_d == S_COUNT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      inc_dly_q   <= 1'b0;
      ena_dly_q   <= 1'b0;
      blk_ena_q   <= 1'b0;
      blk_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TT_BLK_SEL_GUARD_EN
      guard_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      inc_dly_q   <= sel_inc;
      ena_dly_q   <= sel_ena;
      blk_ena_q   <= blk_ena_d;
      blk_rst_n_q <= blk_rst_n_d;
      busy_q      <= busy_d;
`ifdef TT_BLK_SEL_GUARD_EN
      guard_q     <= guard_d;
`endif
    end
  end

  assign blk_ena   = blk_ena_q;
  assign blk_rst_n = blk_rst_n_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tt_blk_sel.sv
// Directed bench for tt_blk_sel. A 10-bit instance covers the match, mismatch, commit
// with a simultaneous increment, priority and reset cases. A 3-bit instance shares the
// stimulus and covers counter saturation.
module tb_tt_blk_sel;

`ifdef TT_BLK_SEL_GUARD_EN
  localparam int GLEN     = 16;  // 2^GUARD_W with GUARD_W = 4
  localparam bit HAS_GRD  = 1'b1;
`else
  localparam int GLEN     = 1;
  localparam bit HAS_GRD  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sel_rst, sel_inc, sel_ena;
  logic [9:0] blk_id;
  logic [2:0] blk_id3;
  logic       blk_ena, blk_rst_n, busy, ovf;
  logic       blk_ena3, blk_rst_n3, busy3, ovf3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt_blk_sel #(.ADDR_W(10), .GUARD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .blk_id(blk_id),
    .sel_rst(sel_rst), .sel_inc(sel_inc), .sel_ena(sel_ena),
    .blk_ena(blk_ena), .blk_rst_n(blk_rst_n), .busy(busy), .ovf(ovf)
  );

  tt_blk_sel #(.ADDR_W(3), .GUARD_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .blk_id(blk_id3),
    .sel_rst(sel_rst), .sel_inc(sel_inc), .sel_ena(sel_ena),
    .blk_ena(blk_ena3), .blk_rst_n(blk_rst_n3), .busy(busy3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge. Inputs are driven and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sel_inc = 1'b1; step();
      sel_inc = 1'b0; step();
    end
  endtask

  task automatic clear_cnt();
    sel_rst = 1'b1; step();
    sel_rst = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel_rst = 1'b0; sel_inc = 1'b0; sel_ena = 1'b0;
    blk_id = 10'd5; blk_id3 = 3'd7;
    step(); step();
    chk("rst_blk_ena",   {31'd0, blk_ena},   32'd0);
    chk("rst_blk_rst_n", {31'd0, blk_rst_n}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_ovf3",      {31'd0, ovf3},      32'd0);
    rst_n = 1'b1; step();

    // In IDLE a commit edge alone does nothing.
    sel_ena = 1'b1; step();
    chk("idle_ignore_ena", {31'd0, blk_ena}, 32'd0);
    sel_ena = 1'b0; step();

    // Match: ID 5, 5 pulses, then commit.
    clear_cnt();
    chk("count_busy", {31'd0, busy}, 32'd1);
    pulses(5);
    sel_ena = 1'b1; step();
    chk("match_blk_ena",   {31'd0, blk_ena},   32'd1);
    chk("match_rst_held",  {31'd0, blk_rst_n}, 32'd0);
    chk("match_busy",      {31'd0, busy},      {31'd0, HAS_GRD});
    for (int i = 1; i < GLEN; i++) begin
      step();
      chk("guard_rst_held", {31'd0, blk_rst_n}, 32'd0);
    end
    step();
    chk("guard_release",   {31'd0, blk_rst_n}, 32'd1);
    chk("active_busy",     {31'd0, busy},      32'd0);
    chk("active_ena",      {31'd0, blk_ena},   32'd1);

    // Deselect by dropping sel_ena.
    sel_ena = 1'b0; step();
    chk("desel_ena",   {31'd0, blk_ena},   32'd0);
    chk("desel_rst_n", {31'd0, blk_rst_n}, 32'd0);
    chk("desel_busy",  {31'd0, busy},      32'd0);

    // Priority: sel_rst in ACTIVE wins, clears cnt, and returns to COUNT.
    clear_cnt(); pulses(5);
    sel_ena = 1'b1; step();
    for (int i = 0; i < GLEN; i++) step();
    chk("pri_pre_active", {31'd0, blk_rst_n}, 32'd1);
    sel_rst = 1'b1; step();
    sel_rst = 1'b0;
    chk("pri_ena",   {31'd0, blk_ena},   32'd0);
    chk("pri_rst_n", {31'd0, blk_rst_n}, 32'd0);
    chk("pri_busy",  {31'd0, busy},      32'd1);
    sel_ena = 1'b0; step();
    pulses(5);              // matches only if the count restarted from 0
    sel_ena = 1'b1; step();
    chk("pri_cnt_cleared", {31'd0, blk_ena}, 32'd1);
    sel_ena = 1'b0; step();

    // Mismatch: 4 pulses against ID 5.
    clear_cnt(); pulses(4);
    sel_ena = 1'b1; step();
    chk("mism_ena",  {31'd0, blk_ena}, 32'd0);
    chk("mism_busy", {31'd0, busy},    32'd0);
    sel_ena = 1'b0; step();

    // Overflow on the 3-bit instance with ID 7.
    clear_cnt(); pulses(7);
    chk("ovf3_at_max", {31'd0, ovf3}, 32'd0);
    pulses(2);
    chk("ovf3_set",    {31'd0, ovf3}, 32'd1);
    chk("ovf10_clear", {31'd0, ovf},  32'd0);
    sel_ena = 1'b1; step();
    chk("ovf3_no_ena",  {31'd0, blk_ena3}, 32'd0);
    chk("ovf3_idle",    {31'd0, busy3},    32'd0);
    sel_ena = 1'b0; step();
    clear_cnt();
    chk("ovf3_cleared", {31'd0, ovf3}, 32'd1 - 32'd1);
    pulses(7);
    sel_ena = 1'b1; step();
    chk("max3_match", {31'd0, blk_ena3}, 32'd1);
    sel_ena = 1'b0; step();

    // Commit with a simultaneous increment uses the count before the increment.
    blk_id = 10'd3;
    clear_cnt(); pulses(3);
    sel_inc = 1'b1; sel_ena = 1'b1; step();
    chk("simul_match", {31'd0, blk_ena}, 32'd1);
    sel_inc = 1'b0; sel_ena = 1'b0; step();
    clear_cnt(); pulses(2);
    sel_inc = 1'b1; sel_ena = 1'b1; step();
    chk("simul_nomatch_ena",  {31'd0, blk_ena}, 32'd0);
    chk("simul_nomatch_busy", {31'd0, busy},    32'd0);
    sel_inc = 1'b0; sel_ena = 1'b0; step();

    // Reset while enabled. This is the guard phase when the guard is built in.
    clear_cnt(); pulses(3);
    sel_ena = 1'b1; step();
    step();
    chk("mid_pre_ena", {31'd0, blk_ena}, 32'd1);
    rst_n = 1'b0; step();
    chk("mid_rst_ena",   {31'd0, blk_ena},   32'd0);
    chk("mid_rst_rst_n", {31'd0, blk_rst_n}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    rst_n = 1'b1; step(); step();
    chk("mid_hold_ena", {31'd0, blk_ena}, 32'd0);
    sel_ena = 1'b0; step();
    sel_ena = 1'b1; step(); step();
    chk("mid_reena_ena",  {31'd0, blk_ena}, 32'd0);
    chk("mid_reena_busy", {31'd0, busy},    32'd0);
    sel_ena = 1'b0; step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
